// File: rtl/layer_sequencer_pkg.sv
// Shared accelerator definitions for the layer sequencer: FSM states,
// default neuron ping-pong buffer bases and launch length.
package layer_sequencer_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH_NK,
        FETCH_NOUT,
        LAUNCH,
        RUN,
        ADVANCE,
        DONE
    } seq_state_e;

    localparam int BUF_A_BASE_DEFAULT = 0;
    localparam int BUF_B_BASE_DEFAULT = 128;

    // Number of cycles ag_read/mac_clear are held when a layer is launched.
    localparam int LAUNCH_CYCLES = 2;

endpackage

// File: rtl/layer_sequencer.sv
// Layer sequencer: walks an {Nk, Nout} program, launches the address generator
// per layer and ping-pongs neuron buffers. Define LAYER_SEQUENCER_WDT_EN for the RUN watchdog.
module layer_sequencer
    import layer_sequencer_pkg::*;
#(
    parameter int ADDR_W     = 8,
    parameter int MAX_LAYERS = 16,
    parameter int BUF_A_BASE = BUF_A_BASE_DEFAULT,
    parameter int BUF_B_BASE = BUF_B_BASE_DEFAULT,
    parameter int WDT_CYCLES = 1023
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic [ADDR_W-1:0] instr_addr,
    input  logic [ADDR_W-1:0] instr_data,
    output logic              ag_read,
    input  logic              ag_finished,
    output logic [ADDR_W-1:0] nk,
    output logic [ADDR_W-1:0] weight_base,
    output logic [ADDR_W-1:0] neuro_read_base,
    output logic [ADDR_W-1:0] neuro_write_base,
    output logic              mac_clear,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [3:0]        layer_idx
);

    localparam logic [ADDR_W-1:0] BUF_A = ADDR_W'(BUF_A_BASE);
    localparam logic [ADDR_W-1:0] BUF_B = ADDR_W'(BUF_B_BASE);
    localparam logic              LAUNCH_LAST = 1'(LAUNCH_CYCLES - 1);

    seq_state_e        state_q;
    logic [ADDR_W-1:0] nk_q, nout_q, wbase_q, rbase_q, wrbase_q;
    logic [3:0]        idx_q;
    logic              launch_q, ag_read_q, mac_clear_q, busy_q, done_q;

    // Weight footprint wraps modulo 2^ADDR_W by construction of the widths.
    logic [ADDR_W-1:0] prod_d, wbase_d;
    logic [4:0]        idx_d;
    logic              last_layer_d;

    assign prod_d       = nk_q * nout_q;
    assign wbase_d      = wbase_q + prod_d;
    assign idx_d        = {1'b0, idx_q} + 5'd1;
    assign last_layer_d = (32'(idx_d) == MAX_LAYERS);

    always_comb begin
        // NOTE: default first so no path leaves instr_addr unassigned (no latch).
        instr_addr = '0;
        case (state_q)
            FETCH_NK:   instr_addr = ADDR_W'({idx_q, 1'b0});
            FETCH_NOUT: instr_addr = ADDR_W'({idx_q, 1'b1});
            default:    ;
        endcase
    end

`ifdef LAYER_SEQUENCER_WDT_EN
    localparam int WDT_W = $clog2(WDT_CYCLES + 1);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);
    logic [WDT_W-1:0] wdt_q;
    logic             error_q;
    assign error = error_q;
`else
    logic wdt_unused;
    assign wdt_unused = ^WDT_CYCLES;
    assign error      = 1'b0;
`endif

    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous and sampled here; all state updates use <=.
        if (!reset) begin
            state_q     <= IDLE;
            nk_q        <= '0;
            nout_q      <= '0;
            wbase_q     <= '0;
            rbase_q     <= BUF_A;
            wrbase_q    <= BUF_B;
            idx_q       <= '0;
            launch_q    <= 1'b0;
            ag_read_q   <= 1'b0;
            mac_clear_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef LAYER_SEQUENCER_WDT_EN
            wdt_q       <= '0;
            error_q     <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q  <= FETCH_NK;
                        idx_q    <= '0;
                        wbase_q  <= '0;
                        rbase_q  <= BUF_A;
                        wrbase_q <= BUF_B;
                        busy_q   <= 1'b1;
`ifdef LAYER_SEQUENCER_WDT_EN
                        error_q  <= 1'b0;
`endif
                    end
                end
                FETCH_NK: begin
                    if (instr_data == '0) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        nk_q    <= instr_data;
                        state_q <= FETCH_NOUT;
                    end
                end
                FETCH_NOUT: begin
                    nout_q      <= (instr_data == '0) ? ADDR_W'(1) : instr_data;
                    state_q     <= LAUNCH;
                    launch_q    <= 1'b0;
                    ag_read_q   <= 1'b1;
                    mac_clear_q <= 1'b1;
                end
                LAUNCH: begin
                    if (launch_q == LAUNCH_LAST) begin
                        state_q     <= RUN;
                        ag_read_q   <= 1'b0;
                        mac_clear_q <= 1'b0;
`ifdef LAYER_SEQUENCER_WDT_EN
                        wdt_q       <= '0;
`endif
                    end else begin
                        launch_q <= launch_q + 1'b1;
                    end
                end
                RUN: begin
                    if (ag_finished) begin
                        state_q <= ADVANCE;
                    end
`ifdef LAYER_SEQUENCER_WDT_EN
                    else if (wdt_q == WDT_LAST) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        wdt_q <= wdt_q + 1'b1;
                    end
`endif
                end
                ADVANCE: begin
                    wbase_q  <= wbase_d;
                    rbase_q  <= wrbase_q;
                    wrbase_q <= rbase_q;
                    idx_q    <= idx_d[3:0];
                    if (last_layer_d) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= FETCH_NK;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign nk               = nk_q;
    assign weight_base      = wbase_q;
    assign neuro_read_base  = rbase_q;
    assign neuro_write_base = wrbase_q;
    assign ag_read          = ag_read_q;
    assign mac_clear        = mac_clear_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign layer_idx        = idx_q;

endmodule
